// File: rtl/cis_seq_pkg.sv
// rtl/cis_seq_pkg.sv - state encoding, register offsets and field positions for the sensor init sequencer
package cis_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PWR_ON,
    ST_RST_REL,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [7:0] OFS_CTRL   = 8'h00;
  localparam logic [7:0] OFS_STATUS = 8'h04;
  localparam logic [7:0] OFS_DEV    = 8'h08;
  localparam logic [7:0] OFS_COUNT  = 8'h0C;
  localparam logic [7:0] OFS_TABLE  = 8'h40;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_ERR       = 2;
  localparam int STAT_RETRY_LSB = 4;
  localparam int STAT_IDX_LSB   = 8;

  localparam int TBL_ENTRIES = 16;

endpackage

// File: rtl/cis_seq_wb_regs.sv
// rtl/cis_seq_wb_regs.sv - Wishbone slave decode, control/config registers and the command table
module cis_seq_wb_regs
  import cis_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h3000_0100
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        busy,
  input  logic        done,
  input  logic        err,
  input  logic [1:0]  retry,
  input  logic [3:0]  index,
  output logic        start_pulse,
  output logic        abort_pulse,
  output logic        irq_en,
  output logic [6:0]  dev,
  output logic [4:0]  count,
  output logic [23:0] entry
);

  logic [23:0] tbl [TBL_ENTRIES];
  logic [7:0]  ofs;
  logic        in_range, access, wr, tbl_hit;
  logic [3:0]  tbl_sel;
  logic [31:0] rdata, status;
  logic        unused_bits;

  // The block claims a 256-byte window; anything outside it is never acked.
  assign ofs      = wbs_adr_i[7:0];
  assign in_range = wbs_adr_i[31:8] == BASE_ADR[31:8];
  assign access   = wbs_cyc_i & wbs_stb_i & in_range & ~wbs_ack_o;
  assign wr       = access & wbs_we_i;
  assign tbl_hit  = ofs[7:6] == OFS_TABLE[7:6];
  assign tbl_sel  = ofs[5:2];

  assign start_pulse = wr && (ofs == OFS_CTRL) && wbs_dat_i[CTRL_START];
  assign abort_pulse = wr && (ofs == OFS_CTRL) && wbs_dat_i[CTRL_ABORT];
  assign entry       = tbl[index];
  assign unused_bits = ^{wbs_sel_i, wbs_dat_i[31:24]};

  always_comb begin
    status                          = '0;
    status[STAT_BUSY]               = busy;
    status[STAT_DONE]               = done;
    status[STAT_ERR]                = err;
    status[STAT_RETRY_LSB +: 2]     = retry;
    status[STAT_IDX_LSB +: 4]       = index;
  end

  always_comb begin
    rdata = '0;
    if (tbl_hit) begin
      rdata = {8'd0, tbl[tbl_sel]};
    end else begin
      case (ofs)
        OFS_CTRL:   rdata[CTRL_IRQ_EN] = irq_en;
        OFS_STATUS: rdata = status;
        OFS_DEV:    rdata = {25'd0, dev};
        OFS_COUNT:  rdata = {27'd0, count};
        default:    rdata = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      irq_en    <= 1'b0;
      dev       <= '0;
      count     <= '0;
      for (int i = 0; i < TBL_ENTRIES; i++) tbl[i] <= '0;
    end else begin
      wbs_ack_o <= access;
      if (access && !wbs_we_i) wbs_dat_o <= rdata;
      if (wr) begin
        if (ofs == OFS_CTRL) irq_en <= wbs_dat_i[CTRL_IRQ_EN];
        // Configuration is frozen while a sequence runs so cmd_* cannot shift under the I2C master.
        if (!busy) begin
          if (tbl_hit)          tbl[tbl_sel] <= wbs_dat_i[23:0];
          if (ofs == OFS_DEV)   dev          <= wbs_dat_i[6:0];
          if (ofs == OFS_COUNT) count        <= wbs_dat_i[4:0];
        end
      end
    end
  end

endmodule

// File: rtl/cis_sensor_init_seq.sv
// rtl/cis_sensor_init_seq.sv - camera sensor power-up and I2C register-table init sequencer
module cis_sensor_init_seq
  import cis_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADR  = 32'h3000_0100,
  parameter int          PWR_WAIT  = 1000,
  parameter int          RST_WAIT  = 1000,
  parameter int          MAX_RETRY = 3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [6:0]  cmd_dev_o,
  output logic [15:0] cmd_reg_o,
  output logic [7:0]  cmd_data_o,
  input  logic        i2c_done_i,
  input  logic        i2c_nack_i,
  output logic        cam_pwr_en_o,
  output logic        cam_reset_o,
  output logic        mipi_en_o,
  output logic        irq_o
);

  state_t      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [4:0]  idx_q, idx_d;
  logic [1:0]  retry_q, retry_d;
  logic        start_pulse, abort_pulse, irq_en, busy, done, err;
  logic [6:0]  dev;
  logic [4:0]  count, count_eff;
  logic [23:0] entry;

  cis_seq_wb_regs #(.BASE_ADR(BASE_ADR)) u_regs (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .retry       (retry_q),
    .index       (idx_q[3:0]),
    .start_pulse (start_pulse),
    .abort_pulse (abort_pulse),
    .irq_en      (irq_en),
    .dev         (dev),
    .count       (count),
    .entry       (entry)
  );

  assign count_eff = (count > 5'd16) ? 5'd16 : count;
  assign busy      = state_q inside {ST_PWR_ON, ST_RST_REL, ST_ISSUE, ST_WAIT, ST_NEXT};
  assign done      = state_q == ST_DONE;
  assign err       = state_q == ST_ERR;

  // Outputs are pure functions of state, so ABORT's return to IDLE drops them in one cycle.
  assign cam_pwr_en_o = state_q != ST_IDLE;
  assign cam_reset_o  = (state_q == ST_IDLE) || (state_q == ST_PWR_ON);
  assign mipi_en_o    = done;
  assign cmd_valid_o  = state_q == ST_ISSUE;
  assign cmd_dev_o    = dev;
  assign cmd_reg_o    = entry[23:8];
  assign cmd_data_o   = entry[7:0];
  assign irq_o        = irq_en & (done | err);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = '0;
    idx_d   = idx_q;
    retry_d = retry_q;
    if (abort_pulse) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_pulse) begin
            state_d = ST_PWR_ON;
            idx_d   = '0;
            retry_d = '0;
          end
        end
        ST_PWR_ON: begin
          if (timer_q + 32'd1 >= 32'(PWR_WAIT)) state_d = ST_RST_REL;
          else                                   timer_d = timer_q + 32'd1;
        end
        ST_RST_REL: begin
          if (timer_q + 32'd1 >= 32'(RST_WAIT)) state_d = (count_eff == 5'd0) ? ST_DONE : ST_ISSUE;
          else                                   timer_d = timer_q + 32'd1;
        end
        ST_ISSUE: begin
          if (cmd_ready_i) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (i2c_done_i) begin
            if (!i2c_nack_i) begin
              state_d = ST_NEXT;
            end else if (32'(retry_q) < 32'(MAX_RETRY)) begin
              retry_d = retry_q + 2'd1;
              state_d = ST_ISSUE;
            end else begin
              state_d = ST_ERR;
            end
          end
        end
        ST_NEXT: begin
          retry_d = '0;
          idx_d   = idx_q + 5'd1;
          state_d = (idx_q + 5'd1 == count_eff) ? ST_DONE : ST_ISSUE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cis_sensor_init_seq.sv
// tb/tb_cis_sensor_init_seq.sv - self-checking bench for the sensor init sequencer
module tb_cis_sensor_init_seq;

  localparam logic [31:0] BASE = 32'h3000_0100;
  localparam int PW = 4;
  localparam int RW = 4;
  localparam int MAXR = 3;
  localparam logic [31:0] A_CTRL = 32'h00, A_STATUS = 32'h04, A_DEV = 32'h08, A_COUNT = 32'h0C, A_TBL = 32'h40;

  logic        clk, rst;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic        wbs_ack_o;
  logic        cmd_valid_o, cmd_ready_i, i2c_done_i, i2c_nack_i;
  logic [6:0]  cmd_dev_o;
  logic [15:0] cmd_reg_o;
  logic [7:0]  cmd_data_o;
  logic        cam_pwr_en_o, cam_reset_o, mipi_en_o, irq_o;

  int n_checks = 0;
  int n_fail = 0;

  cis_sensor_init_seq #(.BASE_ADR(BASE), .PWR_WAIT(PW), .RST_WAIT(RW), .MAX_RETRY(MAXR)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_dev_o(cmd_dev_o),
    .cmd_reg_o(cmd_reg_o), .cmd_data_o(cmd_data_o),
    .i2c_done_i(i2c_done_i), .i2c_nack_i(i2c_nack_i),
    .cam_pwr_en_o(cam_pwr_en_o), .cam_reset_o(cam_reset_o), .mipi_en_o(mipi_en_o), .irq_o(irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic        exp_ack;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs [16];
  logic [6:0]  dev_m;
  logic [23:0] tbl_m [16];
  int          plan [64];
  logic [30:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic got, output logic [31:0] rd);
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = w; wbs_adr_i = a; wbs_dat_i = d;
    @(negedge clk);
    got = wbs_ack_o;
    rd  = wbs_dat_o;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_wr(input logic [31:0] ofs, input logic [31:0] d);
    logic g;
    logic [31:0] r;
    wb_xfer(1'b1, BASE + ofs, d, g, r);
    chk("wr_ack", 32'(g), 1);
  endtask

  task automatic wb_rd(input logic [31:0] ofs, output logic [31:0] d);
    logic g;
    wb_xfer(1'b0, BASE + ofs, 32'd0, g, d);
    chk("rd_ack", 32'(g), 1);
  endtask

  // Waits for a command, optionally stalls it while checking it stays put, then accepts it.
  task automatic accept_cmd(input int stall, output logic [30:0] cmd);
    int n = 0;
    cmd_ready_i = 1'b0;
    while (!cmd_valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_valid_timeout", 32'(n < 100), 1);
    cmd = {cmd_dev_o, cmd_reg_o, cmd_data_o};
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("cmd_stable", {cmd_valid_o, cmd_dev_o, cmd_reg_o, cmd_data_o}, {1'b1, cmd});
    end
    cmd_ready_i = 1'b1;
    @(negedge clk);
    cmd_ready_i = 1'b0;
  endtask

  task automatic pulse_done(input logic nack);
    i2c_done_i = 1'b1;
    i2c_nack_i = nack;
    @(negedge clk);
    i2c_done_i = 1'b0;
    i2c_nack_i = 1'b0;
  endtask

  // Expected command stream and final STATUS word, derived from the sequencing rules.
  function automatic logic [31:0] model_run(input int cnt);
    int eff = (cnt > 16) ? 16 : cnt;
    int k = 0;
    exp_q.delete();
    for (int e = 0; e < eff; e++) begin
      for (int r = 0; r <= MAXR; r++) begin
        exp_q.push_back({dev_m, tbl_m[e]});
        k = k + 1;
        if (plan[k-1] == 0) break;
        if (r == MAXR) return 32'(4 + MAXR * 16 + e * 256);
      end
    end
    return 32'(2 + (eff % 16) * 256);
  endfunction

  task automatic run_random();
    int cnt;
    logic [31:0] exp_st, st;
    logic [30:0] c;
    cnt = $urandom_range(1, 20);
    dev_m = 7'($urandom);
    wb_wr(A_DEV, {25'd0, dev_m});
    for (int e = 0; e < 16; e++) begin
      tbl_m[e] = 24'($urandom);
      wb_wr(A_TBL + 32'(4 * e), {8'($urandom), tbl_m[e]});
    end
    wb_wr(A_COUNT, 32'(cnt));
    for (int i = 0; i < 64; i++) plan[i] = ($urandom_range(0, 2) == 0) ? 1 : 0;
    exp_st = model_run(cnt);
    wb_wr(A_CTRL, 32'h5);
    for (int j = 0; j < exp_q.size(); j++) begin
      accept_cmd($urandom_range(0, 3), c);
      chk("rand_cmd", {1'b0, c}, {1'b0, exp_q[j]});
      repeat ($urandom_range(0, 2)) @(negedge clk);
      pulse_done(plan[j] != 0);
    end
    repeat (3) @(negedge clk);
    chk("rand_no_extra_cmd", 32'(cmd_valid_o), 0);
    wb_rd(A_STATUS, st);
    chk("rand_status", st, exp_st);
    chk("rand_mipi", 32'(mipi_en_o), 32'(exp_st[1]));
  endtask

  initial begin
    logic [31:0] rd;
    logic [30:0] c;
    logic        g, sawv;
    int          n, nrst;

    rst = 1'b1;
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; wbs_sel_i = 4'hF; wbs_adr_i = 0; wbs_dat_i = 0;
    cmd_ready_i = 0; i2c_done_i = 0; i2c_nack_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_cam_reset", 32'(cam_reset_o), 1);
    chk("rst_pwr", 32'(cam_pwr_en_o), 0);
    chk("rst_mipi", 32'(mipi_en_o), 0);
    chk("rst_cmd_valid", 32'(cmd_valid_o), 0);
    chk("rst_irq", 32'(irq_o), 0);
    chk("rst_ack", 32'(wbs_ack_o), 0);
    rst = 1'b0;
    wb_rd(A_STATUS, rd);
    chk("rst_status", rd, 0);

    vecs[0]  = '{1'b1, BASE + 32'h08, 32'hFFFF_FFAB, 1'b1, 32'h0};
    vecs[1]  = '{1'b0, BASE + 32'h08, 32'h0,         1'b1, 32'h2B};
    vecs[2]  = '{1'b1, BASE + 32'h0C, 32'h3F,        1'b1, 32'h0};
    vecs[3]  = '{1'b0, BASE + 32'h0C, 32'h0,         1'b1, 32'h1F};
    vecs[4]  = '{1'b1, BASE + 32'h40, 32'hFF12_3456, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, BASE + 32'h40, 32'h0,         1'b1, 32'h0012_3456};
    vecs[6]  = '{1'b1, BASE + 32'h7C, 32'h00AB_CDEF, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, BASE + 32'h7C, 32'h0,         1'b1, 32'h00AB_CDEF};
    vecs[8]  = '{1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, BASE + 32'h20, 32'h0,         1'b1, 32'h0};
    vecs[10] = '{1'b1, BASE + 32'h00, 32'h4,         1'b1, 32'h0};
    vecs[11] = '{1'b0, BASE + 32'h00, 32'h0,         1'b1, 32'h4};
    vecs[12] = '{1'b0, BASE + 32'h100, 32'h0,        1'b0, 32'h0};
    vecs[13] = '{1'b1, 32'h0000_0100, 32'h5,         1'b0, 32'h0};
    vecs[14] = '{1'b0, BASE + 32'h04, 32'h0,         1'b1, 32'h0};
    vecs[15] = '{1'b0, BASE + 32'h3C, 32'h0,         1'b1, 32'h0};
    for (int i = 0; i < 16; i++) begin
      wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].wdata, g, rd);
      chk($sformatf("vec%0d_ack", i), 32'(g), 32'(vecs[i].exp_ack));
      if (!vecs[i].we && vecs[i].exp_ack) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      @(negedge clk);
      chk($sformatf("vec%0d_ack_single", i), 32'(wbs_ack_o), 0);
    end

    // Two-entry table, all ACKed; busy-time writes must be discarded.
    dev_m = 7'h36;
    tbl_m[0] = 24'h3012_01;
    tbl_m[1] = 24'h0100_01;
    wb_wr(A_DEV, {25'd0, dev_m});
    wb_wr(A_TBL, {8'd0, tbl_m[0]});
    wb_wr(A_TBL + 4, {8'd0, tbl_m[1]});
    wb_wr(A_COUNT, 2);
    wb_wr(A_CTRL, 32'h5);
    chk("seq_pwr_on", 32'(cam_pwr_en_o), 1);
    chk("seq_in_reset", 32'(cam_reset_o), 1);
    wb_wr(A_TBL, 32'h00DE_ADBE);
    wb_rd(A_TBL, rd);
    chk("busy_tbl_unchanged", rd, {8'd0, tbl_m[0]});
    wb_wr(A_COUNT, 7);
    wb_rd(A_COUNT, rd);
    chk("busy_count_unchanged", rd, 2);
    accept_cmd(10, c);
    chk("seq_cmd0", {1'b0, c}, {1'b0, dev_m, tbl_m[0]});
    pulse_done(1'b0);
    accept_cmd(0, c);
    chk("seq_cmd1", {1'b0, c}, {1'b0, dev_m, tbl_m[1]});
    pulse_done(1'b0);
    repeat (2) @(negedge clk);
    chk("seq_mipi", 32'(mipi_en_o), 1);
    chk("seq_irq", 32'(irq_o), 1);
    chk("seq_cam_reset", 32'(cam_reset_o), 0);
    chk("seq_pwr", 32'(cam_pwr_en_o), 1);
    chk("seq_cmd_idle", 32'(cmd_valid_o), 0);
    wb_rd(A_STATUS, rd);
    chk("seq_status", rd, 32'h202);

    // Empty table: straight to DONE after the two waits.
    wb_wr(A_COUNT, 0);
    wb_wr(A_CTRL, 32'h5);
    chk("c0_done_cleared", 32'(mipi_en_o), 0);
    n = 0; nrst = -1; sawv = 1'b0;
    while (!mipi_en_o && n < 100) begin
      @(negedge clk);
      n++;
      if (!cam_reset_o && nrst < 0) nrst = n;
      sawv = sawv | cmd_valid_o;
    end
    chk("c0_done_latency", 32'(n), PW + RW);
    chk("c0_reset_release", 32'(nrst), PW);
    chk("c0_no_cmd", 32'(sawv), 0);

    // Entry 0 NACKed three times then ACKed.
    wb_wr(A_COUNT, 1);
    wb_wr(A_CTRL, 32'h5);
    for (int r = 0; r < 3; r++) begin
      accept_cmd(0, c);
      chk("retry_cmd", {1'b0, c}, {1'b0, dev_m, tbl_m[0]});
      pulse_done(1'b1);
    end
    accept_cmd(0, c);
    wb_rd(A_STATUS, rd);
    chk("retry_count3", rd, 32'h31);
    pulse_done(1'b0);
    repeat (2) @(negedge clk);
    wb_rd(A_STATUS, rd);
    chk("retry_done_status", rd, 32'h102);
    chk("retry_done_mipi", 32'(mipi_en_o), 1);

    // Fourth NACK exhausts the retries.
    wb_wr(A_CTRL, 32'h5);
    for (int r = 0; r < 4; r++) begin
      accept_cmd(0, c);
      pulse_done(1'b1);
    end
    repeat (2) @(negedge clk);
    wb_rd(A_STATUS, rd);
    chk("err_status", rd, 32'h34);
    chk("err_mipi", 32'(mipi_en_o), 0);
    chk("err_pwr_held", 32'(cam_pwr_en_o), 1);
    chk("err_irq", 32'(irq_o), 1);
    chk("err_cmd_idle", 32'(cmd_valid_o), 0);

    // ABORT in WAIT on the same edge as an ACKed i2c_done_i.
    wb_wr(A_CTRL, 32'h5);
    accept_cmd(0, c);
    @(negedge clk);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_adr_i = BASE + A_CTRL; wbs_dat_i = 32'h2;
    i2c_done_i = 1; i2c_nack_i = 0;
    @(negedge clk);
    chk("abort_ack", 32'(wbs_ack_o), 1);
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; i2c_done_i = 0;
    chk("abort_cam_reset", 32'(cam_reset_o), 1);
    chk("abort_pwr", 32'(cam_pwr_en_o), 0);
    chk("abort_cmd_valid", 32'(cmd_valid_o), 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(mipi_en_o), 0);
    wb_rd(A_STATUS, rd);
    chk("abort_status", rd, 0);

    // START and ABORT in one write: ABORT wins.
    wb_wr(A_CTRL, 32'h7);
    repeat (2) @(negedge clk);
    chk("start_abort_pwr", 32'(cam_pwr_en_o), 0);
    wb_rd(A_STATUS, rd);
    chk("start_abort_status", rd, 0);

    for (int i = 0; i < 6; i++) run_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
